// File: rtl/flash_read_arbiter_if.sv
// Requester ports A/B, flash byte-reader handshake and status for flash_read_arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface flash_read_arbiter_if #(
    parameter int unsigned PORT_AW = 18
);
    logic               a_req;
    logic [PORT_AW-1:0] a_addr;
    logic               a_ack;
    logic [7:0]         a_rdata;
    logic               b_req;
    logic [PORT_AW-1:0] b_addr;
    logic               b_ack;
    logic [7:0]         b_rdata;
    logic               flash_ready;
    logic               flash_read_en;
    logic [23:0]        flash_addr;
    logic [7:0]         flash_rdata;
    logic               busy;

    modport master (
        output a_req, a_addr, b_req, b_addr, flash_ready, flash_rdata,
        input  a_ack, a_rdata, b_ack, b_rdata, flash_read_en, flash_addr, busy
    );

    modport slave (
        input  a_req, a_addr, b_req, b_addr, flash_ready, flash_rdata,
        output a_ack, a_rdata, b_ack, b_rdata, flash_read_en, flash_addr, busy
    );
endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin sharing of one QSPI flash byte-reader between two requesters, each port
// relocated by a base offset and fronted by a one-entry last-address cache.
module flash_read_arbiter #(
    parameter int unsigned PORT_AW = 18,
    parameter logic [23:0] A_BASE  = 24'h100000,
    parameter logic [23:0] B_BASE  = 24'h140000
) (
    input logic                 clk,
    input logic                 reset,
    flash_read_arbiter_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StIssue, StWaitLo, StWaitHi, StDone} state_e;

    state_e state_q, state_d;
    // Current grantee while busy, last grantee while idle (1 = port B).
    logic grant_b_q, grant_b_d;
    logic [23:0] flash_addr_q, flash_addr_d;

    logic               a_ack_q, b_ack_q;
    logic               a_valid_q, b_valid_q;
    logic [PORT_AW-1:0] a_tag_q, b_tag_q;
    logic [7:0]         a_data_q, b_data_q;

    logic a_sample, b_sample, a_match, b_match, a_hit, b_hit, a_miss, b_miss;
    logic read_en, capture, busy_int;

    always_comb begin
        busy_int = (state_q != StIdle);
        a_sample = bus.a_req & ~a_ack_q;
        b_sample = bus.b_req & ~b_ack_q;
        a_match  = a_valid_q & (a_tag_q == bus.a_addr);
        b_match  = b_valid_q & (b_tag_q == bus.b_addr);
        // The port owning the flash access is never served from its cache.
        a_hit    = a_sample & a_match & ~(busy_int & ~grant_b_q);
        b_hit    = b_sample & b_match & ~(busy_int & grant_b_q);
        a_miss   = a_sample & ~a_match;
        b_miss   = b_sample & ~b_match;
    end

    always_comb begin
        state_d      = state_q;
        grant_b_d    = grant_b_q;
        flash_addr_d = flash_addr_q;
        read_en      = 1'b0;
        capture      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (a_miss | b_miss) begin
                    grant_b_d    = b_miss & (~a_miss | ~grant_b_q);
                    flash_addr_d = grant_b_d ? B_BASE + 24'(bus.b_addr)
                                             : A_BASE + 24'(bus.a_addr);
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (bus.flash_ready) begin
                    read_en = 1'b1;
                    state_d = StWaitLo;
                end
            end
            StWaitLo: begin
                if (!bus.flash_ready) state_d = StWaitHi;
            end
            StWaitHi: begin
                if (bus.flash_ready) begin
                    capture = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_b_q    <= 1'b1;
            flash_addr_q <= 24'h000000;
        end else begin
            state_q      <= state_d;
            grant_b_q    <= grant_b_d;
            flash_addr_q <= flash_addr_d;
        end
    end

    // The cache data register doubles as the port's rdata: it only changes on a fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_tag_q   <= '0;
            b_tag_q   <= '0;
            a_data_q  <= 8'h00;
            b_data_q  <= 8'h00;
        end else begin
            a_ack_q <= a_hit | (capture & ~grant_b_q);
            b_ack_q <= b_hit | (capture & grant_b_q);
            if (capture && !grant_b_q) begin
                a_valid_q <= 1'b1;
                a_tag_q   <= bus.a_addr;
                a_data_q  <= bus.flash_rdata;
            end
            if (capture && grant_b_q) begin
                b_valid_q <= 1'b1;
                b_tag_q   <= bus.b_addr;
                b_data_q  <= bus.flash_rdata;
            end
        end
    end

    assign bus.a_ack         = a_ack_q;
    assign bus.a_rdata       = a_data_q;
    assign bus.b_ack         = b_ack_q;
    assign bus.b_rdata       = b_data_q;
    assign bus.flash_read_en = read_en;
    assign bus.flash_addr    = flash_addr_q;
    assign bus.busy          = busy_int;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: directed vector table, corner-case sequences and a
// randomized two-port run checked against a transaction-level cache/flash model.
module tb_flash_read_arbiter;
    localparam int unsigned AW     = 18;
    localparam logic [23:0] A_BASE = 24'h100000;
    localparam logic [23:0] B_BASE = 24'h140000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    flash_read_arbiter_if #(.PORT_AW(AW)) bus ();
    flash_read_arbiter_if #(.PORT_AW(AW)) wbus ();

    flash_read_arbiter #(.PORT_AW(AW), .A_BASE(A_BASE), .B_BASE(B_BASE)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    flash_read_arbiter #(.PORT_AW(AW), .A_BASE(A_BASE), .B_BASE(24'hFFFFF0)) u_wrap (
        .clk(clk), .reset(reset), .bus(wbus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    // Flash reader model: ready drops after a strobe, returns after flash_lat cycles.
    int          flash_lat = 4;
    bit          rand_lat  = 1'b0;
    int          fcnt;
    logic [23:0] faddr;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.flash_ready <= 1'b1;
            bus.flash_rdata <= 8'h00;
            fcnt            <= 0;
        end else if (bus.flash_ready && bus.flash_read_en) begin
            bus.flash_ready <= 1'b0;
            fcnt            <= (rand_lat ? int'($urandom_range(5, 1)) : flash_lat) - 1;
            faddr           <= bus.flash_addr;
        end else if (!bus.flash_ready) begin
            if (fcnt == 0) begin
                bus.flash_ready <= 1'b1;
                bus.flash_rdata <= flash_byte(faddr);
            end else begin
                fcnt <= fcnt - 1;
            end
        end
    end

    int          a_strobes = 0, b_strobes = 0, a_acks = 0;
    logic [23:0] strobe_log[$];
    logic        prev_a_ack = 1'b0, prev_b_ack = 1'b0;
    always @(negedge clk) begin
        if (bus.flash_read_en === 1'b1) begin
            strobe_log.push_back(bus.flash_addr);
            if (bus.flash_addr >= B_BASE) b_strobes++;
            else a_strobes++;
        end
        if (bus.a_ack === 1'b1) begin
            a_acks++;
            check("a_ack_not_back_to_back", prev_a_ack, 0);
        end
        if (bus.b_ack === 1'b1) check("b_ack_not_back_to_back", prev_b_ack, 0);
        prev_a_ack = bus.a_ack;
        prev_b_ack = bus.b_ack;
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One request on one port; lat counts edges from raising req to seeing ack.
    task automatic run_txn(input bit pb, input logic [AW-1:0] addr, output int lat,
                           output logic [7:0] data, output int strobes);
        int s0;
        s0 = pb ? b_strobes : a_strobes;
        if (pb) begin bus.b_req = 1'b1; bus.b_addr = addr; end
        else    begin bus.a_req = 1'b1; bus.a_addr = addr; end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(pb ? bus.b_ack : bus.a_ack) && lat < 100);
        data    = pb ? bus.b_rdata : bus.a_rdata;
        strobes = (pb ? b_strobes : a_strobes) - s0;
        if (pb) bus.b_req = 1'b0;
        else    bus.a_req = 1'b0;
    endtask

    task automatic run_pair(input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                            output logic [23:0] first, output logic [23:0] second);
        int n0, cyc;
        bit a_done, b_done;
        n0 = strobe_log.size();
        a_done = 1'b0; b_done = 1'b0; cyc = 0;
        bus.a_req = 1'b1; bus.a_addr = aa;
        bus.b_req = 1'b1; bus.b_addr = ba;
        while (!(a_done && b_done) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.a_ack) begin
                a_done = 1'b1; bus.a_req = 1'b0;
                check("pair_a_data", bus.a_rdata, flash_byte(A_BASE + 24'(aa)));
            end
            if (bus.b_ack) begin
                b_done = 1'b1; bus.b_req = 1'b0;
                check("pair_b_data", bus.b_rdata, flash_byte(B_BASE + 24'(ba)));
            end
        end
        check("pair_both_acked", {a_done, b_done}, 2'b11);
        first  = (strobe_log.size() > n0)     ? strobe_log[n0]     : 24'hxxxxxx;
        second = (strobe_log.size() > n0 + 1) ? strobe_log[n0 + 1] : 24'hxxxxxx;
    endtask

    // Reference model: a per-port last-address cache predicts hit/miss, data is the
    // flash image at BASE + addr, and a hit must not touch the flash.
    task automatic rand_port(input bit pb, input int count);
        logic [AW-1:0] last_addr, addr;
        bit            valid, exp_hit;
        int            lat, strobes;
        logic [7:0]    data;
        valid = 1'b0;
        last_addr = '0;
        for (int i = 0; i < count; i++) begin
            addr = (pb ? 18'h2A000 : 18'h15000) + AW'($urandom_range(3, 0) * 3);
            exp_hit = valid && (last_addr == addr);
            run_txn(pb, addr, lat, data, strobes);
            check(pb ? "rand_b_data" : "rand_a_data", data,
                  flash_byte((pb ? B_BASE : A_BASE) + 24'(addr)));
            check(pb ? "rand_b_strobes" : "rand_a_strobes", strobes, exp_hit ? 0 : 1);
            if (exp_hit) check(pb ? "rand_b_hit_lat" : "rand_a_hit_lat", lat, 1);
            else check(pb ? "rand_b_miss_lat_ok" : "rand_a_miss_lat_ok",
                       (lat >= 4 && lat <= 40), 1);
            last_addr = addr;
            valid = 1'b1;
            repeat (1 + $urandom_range(2, 0)) begin @(posedge clk); #1; end
        end
    endtask

    typedef struct {
        bit            pb;
        logic [AW-1:0] addr;
        bit            hit;
        logic [23:0]   faddr;
        logic [7:0]    data;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t          vecs[7];
    int            lat, strobes, la, lb, sa, sb, s0, w, acks0;
    logic [7:0]    data, da, db;
    logic [23:0]   first, second;

    initial begin
        reset = 1'b1;
        bus.a_req = 1'b0; bus.a_addr = '0; bus.b_req = 1'b0; bus.b_addr = '0;
        wbus.a_req = 1'b0; wbus.a_addr = '0; wbus.b_req = 1'b0; wbus.b_addr = '0;
        wbus.flash_ready = 1'b1; wbus.flash_rdata = 8'h00;

        vecs[0] = '{1'b0, 18'h00010, 1'b0, 24'h100010, 8'hA5};
        vecs[1] = '{1'b0, 18'h00010, 1'b1, 24'h100010, 8'hA5};
        vecs[2] = '{1'b1, 18'h00020, 1'b0, 24'h140020, 8'h91};
        vecs[3] = '{1'b1, 18'h00020, 1'b1, 24'h140020, 8'h91};
        vecs[4] = '{1'b0, 18'h3FFFF, 1'b0, 24'h13FFFF, 8'hB6};
        vecs[5] = '{1'b0, 18'h00010, 1'b0, 24'h100010, 8'hA5};
        vecs[6] = '{1'b1, 18'h00021, 1'b0, 24'h140021, 8'h90};

        @(negedge clk);
        check("rst_a_ack", bus.a_ack, 0);
        check("rst_b_ack", bus.b_ack, 0);
        check("rst_a_rdata", bus.a_rdata, 0);
        check("rst_b_rdata", bus.b_rdata, 0);
        check("rst_read_en", bus.flash_read_en, 0);
        check("rst_flash_addr", bus.flash_addr, 0);
        check("rst_busy", bus.busy, 0);
        do_reset();

        // Port B address plus a high base wraps modulo 2^24.
        wbus.b_req = 1'b1; wbus.b_addr = 18'h00020;
        w = 0;
        while (!wbus.flash_read_en && w < 10) begin @(posedge clk); #1; w++; end
        check("wrap_read_en", wbus.flash_read_en, 1);
        check("wrap_flash_addr", wbus.flash_addr, 24'h000010);
        wbus.b_req = 1'b0;

        for (int i = 0; i < 7; i++) begin
            s0 = strobe_log.size();
            run_txn(vecs[i].pb, vecs[i].addr, lat, data, strobes);
            check($sformatf("vec%0d_data", i), data, vecs[i].data);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].hit ? 1 : 7);
            check($sformatf("vec%0d_strobes", i), strobes, vecs[i].hit ? 0 : 1);
            if (!vecs[i].hit)
                check($sformatf("vec%0d_flash_addr", i),
                      (strobe_log.size() > s0) ? strobe_log[s0] : 24'hxxxxxx, vecs[i].faddr);
            check($sformatf("vec%0d_ack_busy", i), bus.busy, vecs[i].hit ? 0 : 1);
            @(posedge clk); #1;
            check($sformatf("vec%0d_busy_after", i), bus.busy, 0);
        end

        // Req held through the ack is a fresh request one cycle later.
        s0 = a_strobes;
        bus.a_req = 1'b1; bus.a_addr = 18'h00010;
        @(posedge clk); #1 check("held_hit1", bus.a_ack, 1);
        @(posedge clk); #1 check("held_gap", bus.a_ack, 0);
        @(posedge clk); #1 check("held_hit2", bus.a_ack, 1);
        check("held_data", bus.a_rdata, 8'hA5);
        bus.a_req = 1'b0;
        check("held_no_strobe", a_strobes - s0, 0);
        @(posedge clk); #1;

        // Round robin: A first after reset, then pointer follows the last grant.
        do_reset();
        run_pair(18'h01000, 18'h02000, first, second);
        check("rr1_first", first, 24'h101000);
        check("rr1_second", second, 24'h142000);
        run_txn(1'b0, 18'h03000, lat, data, strobes);
        check("rr_single_a_data", data, flash_byte(24'h103000));
        @(posedge clk); #1;
        run_pair(18'h04000, 18'h05000, first, second);
        check("rr2_first", first, 24'h145000);
        check("rr2_second", second, 24'h104000);
        @(posedge clk); #1;

        // B hits its cache while A waits on the flash.
        s0 = a_strobes;
        fork
            run_txn(1'b0, 18'h06000, la, da, sa);
            begin
                w = 0;
                while (a_strobes == s0 && w < 20) begin @(posedge clk); #1; w++; end
                check("hitlo_a_strobe_seen", a_strobes - s0, 1);
                check("hitlo_busy", bus.busy, 1);
                run_txn(1'b1, 18'h05000, lb, db, sb);
            end
        join
        check("hitlo_b_lat", lb, 1);
        check("hitlo_b_data", db, flash_byte(24'h145000));
        check("hitlo_b_strobes", sb, 0);
        check("hitlo_a_lat", la, 7);
        check("hitlo_a_data", da, flash_byte(24'h106000));
        @(posedge clk); #1;

        // Reset while waiting for flash data: no ack, cache stays invalid.
        s0 = a_strobes;
        bus.a_req = 1'b1; bus.a_addr = 18'h07000;
        w = 0;
        while (a_strobes == s0 && w < 20) begin @(posedge clk); #1; w++; end
        @(posedge clk); #2;
        acks0 = a_acks;
        reset = 1'b1;
        bus.a_req = 1'b0;
        #1;
        check("midrst_a_ack", bus.a_ack, 0);
        check("midrst_read_en", bus.flash_read_en, 0);
        check("midrst_busy", bus.busy, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check("midrst_no_ack", a_acks - acks0, 0);
        run_txn(1'b0, 18'h07000, lat, data, strobes);
        check("midrst_reread_strobes", strobes, 1);
        check("midrst_reread_lat", lat, 7);
        check("midrst_reread_data", data, flash_byte(24'h107000));
        @(posedge clk); #1;

        do_reset();
        rand_lat = 1'b1;
        fork
            rand_port(1'b0, 30);
            rand_port(1'b1, 30);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
